// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and constants for the HUB75 scan engine
package hub75_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY
   } state_e;

   // Field index k occupies fb_data[k*DEPTH +: DEPTH]; r0 sits at the top.
   localparam int unsigned F_R0 = 5;
   localparam int unsigned F_G0 = 4;
   localparam int unsigned F_B0 = 3;
   localparam int unsigned F_R1 = 2;
   localparam int unsigned F_G1 = 1;
   localparam int unsigned F_B1 = 0;

   function automatic int unsigned field_lsb(input int unsigned field, input int unsigned depth);
      return field * depth;
   endfunction

   function automatic int unsigned on_width(input int unsigned on_base, input int unsigned depth);
      return $clog2((on_base << (depth - 1)) + 1);
   endfunction

endpackage

// File: rtl/hub75_on_timer.sv
// rtl/hub75_on_timer.sv - loadable down-counter timing the DISPLAY period
module hub75_on_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         run_i,
   output logic         done_o
);

   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (run_i && cnt_q > ONE) begin
         cnt_d = cnt_q - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero load still terminates after one cycle instead of hanging.
   assign done_o = run_i && (cnt_q <= ONE);

endmodule

// File: rtl/hub75_scan.sv
// rtl/hub75_scan.sv - HUB75 panel scan engine with binary-code modulation
module hub75_scan
   import hub75_pkg::*;
#(
   parameter int unsigned COLS     = 32,
   parameter int unsigned ROW_BITS = 4,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned ON_BASE  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
   input  logic [6*DEPTH-1:0]                fb_data,
   output logic [1:0]                        mat_r,
   output logic [1:0]                        mat_g,
   output logic [1:0]                        mat_b,
   output logic [ROW_BITS-1:0]               mat_row,
   output logic                              mat_clk,
   output logic                              mat_lat,
   output logic                              mat_oe,
   output logic                              frame_start
);

   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned DW = on_width(ON_BASE, DEPTH);
   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);

   state_e              state_q, state_d;
   logic [ROW_BITS-1:0] row_q, row_d;
   logic [CW-1:0]       col_q, col_d;
   logic                phase_q, phase_d;
   logic [PW-1:0]       plane_q, plane_d;
   logic [5:0]          rgb_q, rgb_d;
   logic [ROW_BITS-1:0] mat_row_q, mat_row_d;

   logic [5:0]    plane_bits;
   logic [5:0]    pix;
   logic [CW-1:0] col_nxt;
   logic [DW-1:0] on_len;
   logic          timer_load;
   logic          on_done;

   function automatic logic plane_bit(input logic [6*DEPTH-1:0] d, input int unsigned k,
                                      input logic [PW-1:0] p);
      logic [6*DEPTH-1:0] sh;
      sh = d >> (field_lsb(k, DEPTH) + int'(p));
      return sh[0];
   endfunction

   assign plane_bits = {plane_bit(fb_data, F_R0, plane_q), plane_bit(fb_data, F_G0, plane_q),
                        plane_bit(fb_data, F_B0, plane_q), plane_bit(fb_data, F_R1, plane_q),
                        plane_bit(fb_data, F_G1, plane_q), plane_bit(fb_data, F_B1, plane_q)};

   assign col_nxt = col_q + 1'b1;
   assign on_len  = DW'(ON_BASE) << plane_q;

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      phase_d    = phase_q;
      plane_d    = plane_q;
      rgb_d      = rgb_q;
      mat_row_d  = mat_row_q;
      timer_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = PREFETCH;
               row_d   = '0;
               plane_d = '0;
            end
         end
         PREFETCH: begin
            state_d = SHIFT;
            col_d   = '0;
            phase_d = 1'b0;
         end
         SHIFT: begin
            if (!phase_q) begin
               rgb_d   = plane_bits;
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               col_d   = col_nxt;
               if (col_q == COL_LAST) begin
                  state_d = BLANK;
               end
            end
         end
         BLANK: begin
            // Loaded here so the new row address appears together with the latch strobe.
            state_d   = LATCH;
            mat_row_d = row_q;
         end
         LATCH: begin
            state_d    = DISPLAY;
            timer_load = 1'b1;
         end
         DISPLAY: begin
            if (on_done) begin
               if (!en) begin
                  state_d = IDLE;
               end else if (plane_q == PLANE_LAST) begin
                  state_d = PREFETCH;
                  plane_d = '0;
                  row_d   = row_q + 1'b1;
               end else begin
                  state_d = PREFETCH;
                  plane_d = plane_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         phase_q   <= 1'b0;
         plane_q   <= '0;
         rgb_q     <= '0;
         mat_row_q <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         phase_q   <= phase_d;
         plane_q   <= plane_d;
         rgb_q     <= rgb_d;
         mat_row_q <= mat_row_d;
      end
   end

   hub75_on_timer #(
      .W(DW)
   ) u_on_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (timer_load),
      .load_val_i (on_len),
      .run_i      (state_q == DISPLAY),
      .done_o     (on_done)
   );

   // Pixel data is live from the framebuffer in phase 0 and held through the rising shift clock.
   assign pix         = (state_q == SHIFT && !phase_q) ? plane_bits : rgb_q;
   assign mat_r       = {pix[5], pix[2]};
   assign mat_g       = {pix[4], pix[1]};
   assign mat_b       = {pix[3], pix[0]};
   assign mat_row     = mat_row_q;
   assign mat_clk     = (state_q == SHIFT) && phase_q;
   assign mat_lat     = (state_q == LATCH);
   assign mat_oe      = (state_q != DISPLAY);
   assign frame_start = (state_q == PREFETCH) && (row_q == '0) && (plane_q == '0);
   assign fb_addr     = (state_q == SHIFT) ? {row_q, col_nxt} : {row_q, {CW{1'b0}}};

endmodule

// File: tb/tb_hub75_scan.sv
// tb/tb_hub75_scan.sv - self-checking bench for hub75_scan
module tb_hub75_scan;

   localparam int COLS = 4, ROW_BITS = 4, DEPTH = 3, ON_BASE = 2;

   typedef struct {
      int         row;
      int         col;
      logic [17:0] data;
      logic [5:0] p0;
      logic [5:0] p1;
      logic [5:0] p2;
   } vec_t;

   typedef struct {
      int s;
      int row;
      int on;
   } rp_t;

   typedef struct {
      int         cyc;
      logic [5:0] pix;
   } px_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b1;
   logic [5:0]  fb_addr;
   logic [17:0] fb_data = '0;
   logic [1:0]  mat_r, mat_g, mat_b;
   logic [3:0]  mat_row;
   logic        mat_clk, mat_lat, mat_oe, frame_start;

   logic [17:0] mem [64];
   vec_t        tbl [5];
   int          off [3] = '{0, 13, 28};
   int          fs_q [$];
   rp_t         rp_q [$];
   px_t         px_q [$];

   int   vec_cnt = 0;
   int   err_cnt = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;
   logic [3:0] prev_row = '0;
   logic prev_clk = 1'b0;
   int   oe_run = 0;
   int   cur_on = 0;
   logic on_pending = 1'b0;

   hub75_scan #(
      .COLS(COLS), .ROW_BITS(ROW_BITS), .DEPTH(DEPTH), .ON_BASE(ON_BASE)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .fb_addr(fb_addr), .fb_data(fb_data),
      .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b), .mat_row(mat_row),
      .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk) fb_data <= mem[fb_addr];
   always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [5:0] lookup(input int row, input int col, input int plane);
      logic [5:0] r;
      r = '0;
      foreach (tbl[i]) begin
         if (tbl[i].row == row && tbl[i].col == col)
            r = (plane == 0) ? tbl[i].p0 : (plane == 1) ? tbl[i].p1 : tbl[i].p2;
      end
      return r;
   endfunction

   task automatic push_rp(input int s, input int row, input int plane);
      rp_t r;
      px_t p;
      r.s = s; r.row = row; r.on = ON_BASE << plane;
      rp_q.push_back(r);
      for (int c = 0; c < COLS; c++) begin
         p.cyc = s + 2 + 2 * c;
         p.pix = lookup(row, c, plane);
         px_q.push_back(p);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_start) begin
            chk("frame_start_cyc", cyc, (fs_q.size() != 0) ? fs_q.pop_front() : -1);
         end
         if (mat_lat) begin
            rp_t r;
            r = (rp_q.size() != 0) ? rp_q.pop_front() : '{-100, -1, -1};
            chk("latch_cyc", cyc, r.s + 10);
            chk("latch_row", mat_row, r.row);
            cur_on = r.on;
            on_pending = 1'b1;
         end
         if (mat_row !== prev_row) chk("row_change_in_latch", mat_lat, 1);
         if (mat_oe == 1'b0) begin
            oe_run++;
         end else if (oe_run > 0) begin
            chk("oe_low_len", oe_run, on_pending ? cur_on : -1);
            on_pending = 1'b0;
            oe_run = 0;
         end
         if (mat_clk && !prev_clk) begin
            px_t p;
            p = (px_q.size() != 0) ? px_q.pop_front() : '{-1, 6'h00};
            chk("shift_cyc", cyc, p.cyc);
            chk("shift_pix", {mat_r[1], mat_g[1], mat_b[1], mat_r[0], mat_g[0], mat_b[0]}, p.pix);
         end
      end
      prev_row = mat_row;
      prev_clk = mat_clk;
   end

   initial begin
      for (int a = 0; a < 64; a++) mem[a] = '0;
      tbl[0] = '{2, 1, 18'h28000, 6'b100000, 6'b000000, 6'b100000};
      tbl[1] = '{3, 0, 18'h00018, 6'b000010, 6'b000010, 6'b000000};
      tbl[2] = '{3, 3, 18'h00C40, 6'b000100, 6'b001000, 6'b001000};
      tbl[3] = '{7, 2, 18'h3FFFF, 6'b111111, 6'b111111, 6'b111111};
      tbl[4] = '{15, 3, 18'h00004, 6'b000000, 6'b000000, 6'b000001};
      foreach (tbl[i]) mem[tbl[i].row * COLS + tbl[i].col] = tbl[i].data;

      repeat (3) begin
         @(negedge clk);
         chk("rst_oe", mat_oe, 1);
         chk("rst_lat", mat_lat, 0);
         chk("rst_clk", mat_clk, 0);
         chk("rst_row", mat_row, 0);
         chk("rst_rgb", {mat_r, mat_g, mat_b}, 0);
         chk("rst_frame_start", frame_start, 0);
         chk("rst_fb_addr", fb_addr, 0);
      end

      fs_q.push_back(1);
      fs_q.push_back(753);
      for (int i = 0; i < 65; i++) push_rp(1 + (i / 3) * 47 + off[i % 3], (i / 3) % 16, i % 3);
      rst = 1'b1;
      mon_en = 1'b1;

      wait_cyc(1004);
      en = 1'b0;
      wait_cyc(1020);
      chk("idle_oe", mat_oe, 1);
      chk("idle_clk", mat_clk, 0);
      wait_cyc(1030);
      chk("idle_rp_left", rp_q.size(), 0);
      chk("idle_px_left", px_q.size(), 0);
      chk("idle_fs_left", fs_q.size(), 0);

      fs_q.push_back(1031);
      for (int j = 0; j < 7; j++) push_rp(1031 + (j / 3) * 47 + off[j % 3], j / 3, j % 3);
      en = 1'b1;

      wait_cyc(1136);
      chk("disp_oe", mat_oe, 0);
      chk("disp_row", mat_row, 2);
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      chk("async_oe", mat_oe, 1);
      chk("async_row", mat_row, 0);
      chk("async_lat", mat_lat, 0);
      chk("restart_rp_left", rp_q.size(), 0);
      chk("restart_px_left", px_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
- Scan engine for the HUB75 RGB dot-matrix panel on the badge.
- Runs on the divided clock line generated in the top level.
- Reads pixel pairs (upper and lower panel half) from a synchronous framebuffer.
- Drives the panel's serial RGB data, shift clock, latch, output-enable and row address.
- Colour depth comes from binary-code modulation (BCM) over DEPTH bit-planes per channel.

Parameters:
- COLS, 32, columns shifted per row (power of two, at least 2).
- ROW_BITS, 4, row address width; 2**ROW_BITS scan rows per half.
- DEPTH, 3, bit-planes per colour channel.
- ON_BASE, 8, display cycles for plane 0; plane p lights for ON_BASE<<p cycles.

Ports:
- clk  in  1  scan clock (divided clock line).
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable, sampled in IDLE and at end of each row-plane.
- fb_addr  out  ROW_BITS+log2(COLS)  framebuffer read address, {row, col}.
- fb_data  in  6*DEPTH  read data, one cycle after fb_addr; fields msb→lsb: r0, g0, b0, r1, g1, b1, each DEPTH bits.
- mat_r  out  2  red data, bit1 = upper half (r0), bit0 = lower half (r1).
- mat_g  out  2  green data, same layout.
- mat_b  out  2  blue data, same layout.
- mat_row  out  ROW_BITS  row address of the currently displayed row.
- mat_clk  out  1  panel shift clock; panel samples on rising edge.
- mat_lat  out  1  latch strobe, active high.
- mat_oe  out  1  output enable, active-low (1 = blanked).
- frame_start  out  1  one-cycle pulse when row 0, plane 0 begins shifting.

Behaviour:
Reset (rst=0, asynchronous) sets all of the following; release is synchronous to clk:
- mat_r, mat_g, mat_b, mat_row, fb_addr: 0.
- mat_clk, mat_lat, frame_start: 0.
- mat_oe: 1.
- state: IDLE; row counter, column counter, plane counter: 0.

States and transitions:
- IDLE: mat_oe=1, mat_clk=0. When en=1, go to PREFETCH with row=0, plane=0. frame_start pulses on this transition.
- PREFETCH (1 cycle): fb_addr={row,0}, mat_oe=1. Go to SHIFT.
- SHIFT (2*COLS cycles), col from 0 to COLS-1, phase bit toggling:
  - phase 0: mat_clk=0; mat_r/g/b take bit[plane] of each field of fb_data; fb_addr={row,col+1}. The address wraps at COLS; the wrapped read is don't-care.
  - phase 1: mat_clk=1; data held.
  - After phase 1 of col COLS-1, go to BLANK.
- BLANK (1 cycle): mat_oe=1, mat_clk=0.
- LATCH (1 cycle): mat_lat=1, mat_row<=row, mat_oe=1.
- DISPLAY (ON_BASE<<plane cycles): mat_oe=0, mat_lat=0. On completion:
  - If en=0: go to IDLE, mat_oe=1.
  - If plane<DEPTH-1: plane+1, go to PREFETCH.
  - Otherwise: plane=0 and row+1. If row wraps from 2**ROW_BITS-1 to 0, pulse frame_start on entry to PREFETCH.
- mat_oe is 1 in every state except DISPLAY. mat_lat is 1 only in LATCH.

Timing and arithmetic:
- Cycles per row-plane: 2*COLS+3+(ON_BASE<<plane).
- The display counter is wide enough for ON_BASE<<(DEPTH-1). It loads on entry to DISPLAY and counts down to 1.

Boundary conditions:
- en deasserted mid-shift: the current row-plane completes, including DISPLAY, then the block goes to IDLE.
- en reasserted in IDLE: restart at row 0, plane 0; frame_start pulses.
- Reset mid-DISPLAY: mat_oe goes to 1 immediately (asynchronous).
- Column and row counters wrap modulo their widths. No other saturation.

Decomposition:
- Package hub75_pkg holds:
  - state enum {IDLE, PREFETCH, SHIFT, BLANK, LATCH, DISPLAY};
  - fb_data field offset constants (R0..B1 = k*DEPTH);
  - a localparam function for the display-length width.
- One sub-module is natural: hub75_on_timer. It is a loadable down-counter with a done flag, used for the DISPLAY period.

Test Plan (COLS=4, ROW_BITS=4, DEPTH=3, ON_BASE=2; framebuffer model with 1-cycle latency):
- Reset: hold rst=0 for 3 cycles, en=1 → mat_oe=1, mat_lat=0, mat_clk=0, mat_row=0, mat_r/g/b=0, frame_start=0 throughout.
- Timing: release reset, en=1 → frame_start at cycle 1; row-plane lengths 13, 15, 19 cycles; 47 cycles per row; frame_start repeats every 752 cycles.
- Data: fb pixel (row 2, col 1) = r0=3'b101, all other fields 0; every other pixel 0 → during row 2, mat_r[1] is 1 at the col-1 rising mat_clk for planes 0 and 2, and 0 for plane 1.
- Latch/row: mat_row changes only in the mat_lat=1 cycle. mat_row=2 first appears at the plane-0 latch of row 2. mat_oe=0 for exactly 2, 4, 8 cycles per plane.
- Enable: drop en during row 5, plane 1, SHIFT → plane 1 DISPLAY completes (4 cycles), then IDLE with mat_oe=1. Reassert en → frame_start, row 0, plane 0.
- Async reset: assert rst mid-DISPLAY → mat_oe=1 and mat_row=0 before the next clk edge.
